hybrid_root_finder: RTL

//  Closed-loop current-reference search for the front-end control path: drives i_ref so that
//  the measured Q (q_measured) matches q_desired within TOL. Successor to the fixed bisection
//  and secant controllers: one block, runtime-selectable mode, secant with bracketed

---
 rtl/hybrid_root_finder_if.sv | 29 ++
 rtl/hybrid_root_finder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/hybrid_root_finder_if.sv
// Handshake bundle between the root-finder controller and its driver/plant.
// The master side drives control and measurements; the slave side is the controller.
interface hybrid_root_finder_if #(
  parameter int BUS_WIDTH = 10,
  parameter int MAX_ITER  = 16
);
  localparam int ITER_W = $clog2(MAX_ITER + 1);

  logic                 enable;
  logic                 mode;
  logic                 ready;
  logic [BUS_WIDTH-1:0] q_desired;
  logic [BUS_WIDTH-1:0] q_measured;
  logic [BUS_WIDTH-1:0] i_ref;
  logic                 busy;
  logic                 converged;
  logic                 went_unstable;
  logic [ITER_W-1:0]    iter_count;

  modport master (
    output enable, mode, ready, q_desired, q_measured,
    input  i_ref, busy, converged, went_unstable, iter_count
  );

  modport slave (
    input  enable, mode, ready, q_desired, q_measured,
    output i_ref, busy, converged, went_unstable, iter_count
  );
endinterface

// File: rtl/hybrid_root_finder.sv
// Closed-loop current-reference search: bisection or secant with bisection fallback,
// bracketed on [0, 2^BUS_WIDTH-1], with settle delay and iteration budget.
module hybrid_root_finder #(
  parameter int BUS_WIDTH     = 10,
  parameter int TOL           = 1,
  parameter int MAX_ITER      = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  hybrid_root_finder_if.slave  bus
);
  localparam int W  = BUS_WIDTH;
  localparam int FW = W + 1;
  localparam int NW = 2 * W + 1;
  localparam int DW = W + 2;
  localparam int RW = W + 3;
  localparam int IW = $clog2(MAX_ITER + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int CW = $clog2(NW + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_EVAL_A, S_EVAL_B, S_CHECK, S_COMPUTE, S_APPLY, S_WAIT, S_DONE, S_FAIL
  } state_t;

  function automatic logic [FW-1:0] f_abs(input logic signed [FW-1:0] f);
    if (f[FW-1]) return -f;
    else         return f;
  endfunction

  // Three-valued sign: negative, zero, positive are all distinct.
  function automatic logic [1:0] f_sgn(input logic signed [FW-1:0] f);
    return {f[FW-1], (f == '0)};
  endfunction

  state_t                r_state, w_next;
  logic [W-1:0]          r_a, r_b, r_i_ref, r_qd;
  logic signed [FW-1:0]  r_fa, r_fb;
  logic                  r_mode, r_busy, r_conv, r_unst;
  logic [IW-1:0]         r_iter;
  logic [SW-1:0]         r_settle;
  logic [NW-1:0]         r_num, r_quo;
  logic [DW-1:0]         r_den;
  logic [RW-1:0]         r_rem;
  logic                  r_neg, r_dzero;
  logic [CW-1:0]         r_div_cnt;

  logic signed [FW-1:0]  w_f, w_fb_eff;
  logic signed [DW-1:0]  w_den_s;
  logic [FW-1:0]         w_abs_fa, w_abs_fb;
  logic [W-1:0]          w_span, w_mid, w_best, w_c;
  logic [RW-1:0]         w_rem_sh;
  logic                  w_sample, w_min_ok, w_rem_ge, w_q_ok;

  assign w_f      = signed'({1'b0, bus.q_measured}) - signed'({1'b0, r_qd});
  assign w_sample = (r_settle == '0) && bus.ready;
  assign w_fb_eff = (r_state == S_EVAL_B) ? w_f : r_fb;
  assign w_abs_fa = f_abs(r_fa);
  assign w_abs_fb = f_abs(w_fb_eff);
  assign w_min_ok = (w_abs_fa <= FW'(TOL)) || (w_abs_fb <= FW'(TOL));
  assign w_best   = (w_abs_fb < w_abs_fa) ? r_b : r_a;
  assign w_span   = r_b - r_a;
  assign w_mid    = W'(({1'b0, r_a} + {1'b0, r_b}) >> 1);
  assign w_den_s  = signed'({r_fb[FW-1], r_fb}) - signed'({r_fa[FW-1], r_fa});
  assign w_rem_sh = {r_rem[RW-2:0], r_num[NW-1]};
  assign w_rem_ge = (w_rem_sh >= {1'b0, r_den});
  // A secant step is usable only if it lands strictly inside (a, b).
  assign w_q_ok   = !r_dzero && !r_neg && (r_quo != '0) && (r_quo < NW'(w_span));
  assign w_c      = (r_mode && w_q_ok) ? (r_b - r_quo[W-1:0]) : w_mid;

  assign bus.i_ref         = r_i_ref;
  assign bus.busy          = r_busy;
  assign bus.converged     = r_conv;
  assign bus.went_unstable = r_unst;
  assign bus.iter_count    = r_iter;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; dropping enable while busy aborts to IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.enable) w_next = S_EVAL_A; else w_next = S_IDLE;
      S_EVAL_A:  if (w_sample) w_next = S_EVAL_B; else w_next = S_EVAL_A;
      S_EVAL_B: begin
        if (!w_sample)                          w_next = S_EVAL_B;
        else if (w_min_ok)                      w_next = S_DONE;
        else if (f_sgn(r_fa) == f_sgn(w_f))     w_next = S_FAIL;
        else                                    w_next = S_CHECK;
      end
      S_CHECK: begin
        if (w_span <= W'(1))                    w_next = w_min_ok ? S_DONE : S_FAIL;
        else if (r_iter == IW'(MAX_ITER))       w_next = S_FAIL;
        else if (r_mode)                        w_next = S_COMPUTE;
        else                                    w_next = S_APPLY;
      end
      S_COMPUTE: if (r_div_cnt == CW'(NW - 1)) w_next = S_APPLY; else w_next = S_COMPUTE;
      S_APPLY:   w_next = S_WAIT;
      S_WAIT: begin
        if (!w_sample)                          w_next = S_WAIT;
        else if (f_abs(w_f) <= FW'(TOL))        w_next = S_DONE;
        else                                    w_next = S_CHECK;
      end
      S_DONE, S_FAIL: if (!bus.enable) w_next = S_IDLE; else w_next = r_state;
      default:   w_next = S_IDLE;
    endcase
    if (r_busy && !bus.enable) w_next = S_IDLE;
    else                       w_next = w_next;
  end

  // Datapath: bracket, samples, divider, settle timer and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0; r_b <= '0; r_i_ref <= '0; r_qd <= '0; r_fa <= '0; r_fb <= '0;
      r_mode <= 1'b0; r_busy <= 1'b0; r_conv <= 1'b0; r_unst <= 1'b0;
      r_iter <= '0; r_settle <= '0; r_num <= '0; r_quo <= '0; r_den <= '0;
      r_rem <= '0; r_neg <= 1'b0; r_dzero <= 1'b0; r_div_cnt <= '0;
    end else if (r_busy && !bus.enable) begin
      r_busy <= 1'b0;
    end else begin
      if (r_settle != '0) r_settle <= r_settle - 1'b1;
      case (r_state)
        S_IDLE: if (bus.enable) begin
          r_qd <= bus.q_desired; r_mode <= bus.mode;
          r_a <= '0; r_b <= '1; r_i_ref <= '0;
          r_busy <= 1'b1; r_conv <= 1'b0; r_unst <= 1'b0; r_iter <= '0;
          r_settle <= SW'(SETTLE_CYCLES - 1);
        end
        S_EVAL_A: if (w_sample) begin
          r_fa <= w_f; r_i_ref <= r_b; r_settle <= SW'(SETTLE_CYCLES - 1);
        end
        S_EVAL_B: if (w_sample) r_fb <= w_f;
        S_CHECK: if (w_next == S_COMPUTE) begin
          r_num <= NW'(w_abs_fb) * NW'(w_span);
          r_den <= w_den_s[DW-1] ? DW'(-w_den_s) : DW'(w_den_s);
          r_neg <= r_fb[FW-1] ^ w_den_s[DW-1];
          r_dzero <= (w_den_s == '0);
          r_rem <= '0; r_quo <= '0; r_div_cnt <= '0;
        end
        S_COMPUTE: begin
          r_rem <= w_rem_ge ? (w_rem_sh - {1'b0, r_den}) : w_rem_sh;
          r_quo <= {r_quo[NW-2:0], w_rem_ge};
          r_num <= {r_num[NW-2:0], 1'b0};
          r_div_cnt <= r_div_cnt + 1'b1;
        end
        S_APPLY: begin
          r_i_ref <= w_c; r_iter <= r_iter + 1'b1; r_settle <= SW'(SETTLE_CYCLES - 1);
        end
        S_WAIT: if (w_next == S_CHECK) begin
          if (f_sgn(w_f) == f_sgn(r_fa)) begin r_a <= r_i_ref; r_fa <= w_f; end
          else                           begin r_b <= r_i_ref; r_fb <= w_f; end
        end
        default: ;
      endcase
      if (w_next == S_DONE && r_state != S_DONE) begin
        r_busy <= 1'b0; r_conv <= 1'b1;
        if (r_state != S_WAIT) r_i_ref <= w_best;
      end
      if (w_next == S_FAIL && r_state != S_FAIL) begin
        r_busy <= 1'b0; r_unst <= 1'b1; r_i_ref <= w_best;
      end
    end
  end
endmodule
